// File: rtl/handshake_responder.sv
// handshake_responder: req/ack responder with a clamped, per-request ack latency.
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous active-high reset
//   req          - request, held high by the initiator until ack
//   req_data     - request payload, captured in the accept cycle
//   delay_sel    - requested ack latency, captured in the accept cycle
//   ack          - one-cycle acknowledge pulse
//   rsp_data     - inverted captured payload while ack=1, zero otherwise
//   busy         - high whenever the FSM is outside IDLE
//   req_drop_err - one-cycle pulse when req falls before ack
//   done_count   - saturating count of completed handshakes
module handshake_responder #(
    parameter int MIN_ACK_CYCLE = 2,
    parameter int MAX_ACK_CYCLE = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [3:0]            delay_sel,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  req_drop_err,
    output logic [15:0]           done_count
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;

    localparam logic [3:0] MIN_L = 4'(MIN_ACK_CYCLE);
    localparam logic [3:0] MAX_L = 4'(MAX_ACK_CYCLE);

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] rsp_q;
    logic                  busy_q;
    logic                  err_q;
    logic [15:0]           done_q;
    logic [3:0]            lat_d;

    assign lat_d = delay_sel < MIN_L ? MIN_L : (delay_sel > MAX_L ? MAX_L : delay_sel);

    // Counter holds L-1 in the first WAIT cycle and counts down to 1, so WAIT
    // spans L-1 cycles and ACK lands in cycle L. A drop takes priority over ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            rsp_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            rsp_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (req) begin
                    state_q <= WAIT;
                    data_q  <= req_data;
                    cnt_q   <= lat_d - 4'd1;
                    busy_q  <= 1'b1;
                end
                WAIT: if (!req) begin
                    state_q <= IDLE;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end else if (cnt_q <= 4'd1) begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                    rsp_q   <= ~data_q;
                    done_q  <= done_q == 16'hFFFF ? done_q : done_q + 16'd1;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                ACK: state_q <= RELEASE;
                RELEASE: if (!req) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack          = ack_q;
    assign rsp_data     = rsp_q;
    assign busy         = busy_q;
    assign req_drop_err = err_q;
    assign done_count   = done_q;
endmodule

// File: doc/handshake_responder.md
HANDSHAKE_RESPONDER -- requirements
Module: handshake_responder

Interface
REQ-001 SHALL have parameter MIN_ACK_CYCLE, default 2: minimum req-to-ack latency in cycles.
REQ-002 SHALL have parameter MAX_ACK_CYCLE, default 4: maximum req-to-ack latency in cycles; legal range MIN_ACK_CYCLE..15.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: width of request and response data.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, 1: request from the initiator, held high until ack.
REQ-007 SHALL have port req_data, input, DATA_WIDTH: request payload, valid in the first req-high cycle.
REQ-008 SHALL have port delay_sel, input, 4: requested ack latency, sampled with req_data.
REQ-009 SHALL have port ack, output, 1: single-cycle acknowledge pulse.
REQ-010 SHALL have port rsp_data, output, DATA_WIDTH: response payload, valid only while ack=1.
REQ-011 SHALL have port busy, output, 1: high from the accept cycle until the return to IDLE.
REQ-012 SHALL have port req_drop_err, output, 1: one-cycle pulse when req falls before ack.
REQ-013 SHALL have port done_count, output, 16: count of completed handshakes, saturating.

Function
REQ-014 SHALL implement the states IDLE, WAIT, ACK and RELEASE.
REQ-015 SHALL, in IDLE, accept a request in the first cycle it samples req=1 (cycle 0), then go to WAIT.
REQ-016 SHALL, in the accept cycle, capture req_data and the latency L = delay_sel clamped to [MIN_ACK_CYCLE, MAX_ACK_CYCLE].
REQ-017 SHALL load the latency counter with L-1 on accept and decrement it once per cycle in WAIT.
REQ-018 SHALL assert ack during cycle L exactly, counted from cycle 0, so ack is visible L clock edges after req is first sampled.
REQ-019 SHALL hold ack high for exactly one cycle (state ACK), then go to RELEASE.
REQ-020 SHALL drive rsp_data = captured req_data XOR {DATA_WIDTH{1'b1}} while ack=1, and all zeros otherwise.
REQ-021 SHALL stay in RELEASE while req=1 and go to IDLE on the first cycle req=0.
REQ-022 SHALL NOT accept a new request while req is held high after ack; a new handshake needs req low for at least one sampled cycle.
REQ-023 SHALL, if req=0 is sampled in WAIT before ack:
  - pulse req_drop_err for one cycle;
  - go to IDLE and suppress ack;
  - leave done_count unchanged.
REQ-024 SHALL ignore delay_sel and req_data changes after the accept cycle.
REQ-025 SHALL increment done_count by 1 in each ACK cycle, saturating at 16'hFFFF with no wrap.
REQ-026 SHALL drive busy=1 in WAIT, ACK and RELEASE, and busy=0 in IDLE.
REQ-027 SHALL, when req falls in the same cycle that ack is high, still complete the handshake, go RELEASE then IDLE next cycle, and raise no error.
REQ-028 SHALL, for L=MIN_ACK_CYCLE=2, take one WAIT cycle; WAIT SHALL always last L-1 cycles.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, force state=IDLE, ack=0, rsp_data=0, busy=0, req_drop_err=0, done_count=0 and clear captured data and counter.
REQ-030 SHALL give reset priority over all transitions, including mid-WAIT, ACK or RELEASE; no ack pulse follows a reset.
REQ-031 SHALL treat req=1 sampled in the first cycle after reset deasserts as a new request (cycle 0).

Verification
REQ-032 SHALL cover: req rises with req_data=8'h5A, delay_sel=3, held high -> ack=1 exactly 3 cycles later with rsp_data=8'hA5; done_count=1.
REQ-033 SHALL cover: delay_sel=0, then delay_sel=9 -> ack latency 2, then 4 (clamped).
REQ-034 SHALL cover: delay_sel=4, req dropped after 2 cycles -> req_drop_err pulses once, no ack, done_count unchanged, busy=0 the following cycle.
REQ-035 SHALL cover: req held high 5 cycles beyond ack -> no second ack; after req low 1 cycle and high again -> new handshake accepted.
REQ-036 SHALL cover: reset=1 asserted in the cycle before the expected ack -> ack never asserts, all outputs 0 next cycle.
REQ-037 SHALL cover: 65,540 back-to-back handshakes -> done_count saturates at 16'hFFFF.
